seq_mag_comparator: RTL

Parametrised, handshaked magnitude comparator for multi-bit operands. Compares two WIDTH-bit operands as unsigned or signed, CHUNK bits per cycle, MSB chunk first. Produces mutually exclusive equal, greater and less flags for a downstream consumer. Generalises the team's single-bit combinational e/g/l comparator to wide operands, signed mode and valid/ready flow control.

---
 rtl/seq_mag_comparator.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seq_mag_comparator.sv
// Handshaked magnitude comparator: compares CHUNK bits per cycle, MSB chunk first, unsigned or signed.
// Build option CMP_EARLY_EXIT_EN ends the compare at the first differing chunk.
module seq_mag_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    input  logic                          is_signed,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          e,
    output logic                          g,
    output logic                          l,
    output logic [$clog2(WIDTH/CHUNK):0]  out_cycles
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(NCHUNK) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [CW-1:0]     step_r;
    logic              decided_r;
    logic              dec_g_r;

    logic [CHUNK-1:0]  chunk_a_s;
    logic [CHUNK-1:0]  chunk_b_s;
    logic              diff_s;
    logic              gt_s;
    logic              last_s;
    logic              decided_s;
    logic              dec_g_s;
    logic              finish_s;

    // Flipping the sign bit of both operands turns a two's-complement order into an unsigned one.
    function automatic logic [WIDTH-1:0] bias_msb(input logic [WIDTH-1:0] v, input logic sgn);
        logic [WIDTH-1:0] r;
        r          = v;
        r[WIDTH-1] = v[WIDTH-1] ^ sgn;
        return r;
    endfunction

    assign in_ready = (state_r == IDLE);

    // Current chunk compare; operands are shifted so the active chunk always sits at the top.
    always_comb begin
        chunk_a_s = a_r[WIDTH-1 -: CHUNK];
        chunk_b_s = b_r[WIDTH-1 -: CHUNK];
        diff_s    = (chunk_a_s != chunk_b_s);
        gt_s      = (chunk_a_s > chunk_b_s);
        last_s    = (step_r == CW'(NCHUNK - 1));
        decided_s = decided_r | diff_s;
        dec_g_s   = decided_r ? dec_g_r : gt_s;
`ifdef CMP_EARLY_EXIT_EN
        finish_s  = last_s | diff_s;
`else
        finish_s  = last_s;
`endif
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            a_r        <= '0;
            b_r        <= '0;
            step_r     <= '0;
            decided_r  <= 1'b0;
            dec_g_r    <= 1'b0;
            out_valid  <= 1'b0;
            e          <= 1'b0;
            g          <= 1'b0;
            l          <= 1'b0;
            out_cycles <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r       <= bias_msb(a, is_signed);
                        b_r       <= bias_msb(b, is_signed);
                        step_r    <= '0;
                        decided_r <= 1'b0;
                        dec_g_r   <= 1'b0;
                        state_r   <= CMP;
                    end
                end
                CMP: begin
                    if (finish_s) begin
                        state_r    <= DONE;
                        out_valid  <= 1'b1;
                        e          <= ~decided_s;
                        g          <= decided_s & dec_g_s;
                        l          <= decided_s & ~dec_g_s;
                        out_cycles <= step_r + CW'(1);
                    end else begin
                        step_r    <= step_r + CW'(1);
                        decided_r <= decided_s;
                        dec_g_r   <= dec_g_s;
                        a_r       <= a_r << CHUNK;
                        b_r       <= b_r << CHUNK;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        e         <= 1'b0;
                        g         <= 1'b0;
                        l         <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                    e         <= 1'b0;
                    g         <= 1'b0;
                    l         <= 1'b0;
                end
            endcase
        end
    end

endmodule
